// File: rtl/fx_reg_bank_pkg.sv
// Shared definitions for the fx register page: offsets, fixed values, CTRL bits.
package fx_reg_bank_pkg;

  localparam logic [7:0] FX_VER_VAL  = 8'h01;

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_VER     = 8'h01;
  localparam logic [7:0] OFF_SCRATCH = 8'h02;
  localparam logic [7:0] OFF_CTRL    = 8'h03;
  localparam logic [7:0] OFF_TMR0    = 8'h04;
  localparam logic [7:0] OFF_TMR1    = 8'h05;
  localparam logic [7:0] OFF_TMR2    = 8'h06;
  localparam logic [7:0] OFF_TMR3    = 8'h07;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/us_timer.sv
// Free-running microsecond counter with synchronous clear and a read snapshot shadow.
module us_timer
  import fx_reg_bank_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] tmr_val,
  output logic [31:0] shadow
);

  logic [31:0] cnt_q;
  logic [31:0] shadow_q;

  // Clear wins over a coincident tick; natural 32-bit wrap on overflow.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && tick) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Snapshot captures the value being returned as byte0 on the same edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (snap) begin
      shadow_q <= cnt_q;
    end
  end

  assign tmr_val = cnt_q;
  assign shadow  = shadow_q;

endmodule

// File: rtl/fx_reg_bank.sv
// fx register page: ID/VER/SCRATCH/CTRL plus byte view of the microsecond timer.
module fx_reg_bank
  import fx_reg_bank_pkg::*;
#(
  parameter logic [7:0] BASE   = 8'h00,
  parameter logic [7:0] DEV_ID = 8'hA5
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [15:0] fx_waddr,
  input  logic        fx_wr,
  input  logic [7:0]  fx_data,
  input  logic [15:0] fx_raddr,
  input  logic        fx_rd,
  output logic [7:0]  fx_q,
  output logic        tmr_en,
  output logic [31:0] tmr_val
);

  logic        wr_hit;
  logic        rd_hit;
  logic [7:0]  woff;
  logic [7:0]  roff;
  logic [7:0]  scratch_q;
  logic        tmr_en_q;
  logic        tmr_clr;
  logic        snap;
  logic [31:0] shadow;
  logic [7:0]  rd_data;

  assign woff   = fx_waddr[7:0];
  assign roff   = fx_raddr[7:0];
  assign wr_hit = fx_wr && (fx_waddr[15:8] == BASE);
  assign rd_hit = fx_rd && (fx_raddr[15:8] == BASE);

  assign tmr_clr = wr_hit && (woff == OFF_CTRL) && fx_data[CTRL_CLR_BIT];
  assign snap    = rd_hit && (roff == OFF_TMR0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      tmr_en_q  <= 1'b0;
    end else if (wr_hit) begin
      if (woff == OFF_SCRATCH) scratch_q <= fx_data;
      if (woff == OFF_CTRL)    tmr_en_q  <= fx_data[CTRL_EN_BIT];
    end
  end

  us_timer u_timer (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .tick    (pluse_us),
    .en      (tmr_en_q),
    .clr     (tmr_clr),
    .snap    (snap),
    .tmr_val (tmr_val),
    .shadow  (shadow)
  );

  // Mux sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_data = 8'h00;
    if (fx_raddr[15:8] == BASE) begin
      case (roff)
        OFF_ID:      rd_data = DEV_ID;
        OFF_VER:     rd_data = FX_VER_VAL;
        OFF_SCRATCH: rd_data = scratch_q;
        OFF_CTRL:    rd_data = {7'b0, tmr_en_q};
        OFF_TMR0:    rd_data = word_byte(tmr_val, 2'd0);
        OFF_TMR1:    rd_data = word_byte(shadow, 2'd1);
        OFF_TMR2:    rd_data = word_byte(shadow, 2'd2);
        OFF_TMR3:    rd_data = word_byte(shadow, 2'd3);
        default:     rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q <= '0;
    end else if (fx_rd) begin
      fx_q <= rd_data;
    end
  end

  assign tmr_en = tmr_en_q;

endmodule

// File: doc/fx_reg_bank.md
FX_REG_BANK -- requirements
Module: fx_reg_bank

Interface
REQ-001 Parameter BASE, default 8'h00: fx address page (addr[15:8]) this block decodes.
REQ-002 Parameter DEV_ID, default 8'hA5: value returned by the ID register.
REQ-003 Port clk_sys  in  1: single system clock; all logic is on its rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 Port pluse_us  in  1: one-cycle strobe, once per microsecond, from clock/reset block.
REQ-006 Port fx_waddr  in  16: write address from commu_top.
REQ-007 Port fx_wr  in  1: one-cycle write strobe.
REQ-008 Port fx_data  in  8: write data, valid with fx_wr.
REQ-009 Port fx_raddr  in  16: read address.
REQ-010 Port fx_rd  in  1: one-cycle read strobe.
REQ-011 Port fx_q  out  8: read data.
REQ-012 Port tmr_en  out  1: timer enable (CTRL bit0).
REQ-013 Port tmr_val  out  32: live microsecond counter.

Function
REQ-014 Decode: the block SHALL act only when addr[15:8]==BASE; other pages are ignored for writes and return 8'h00 on reads.
REQ-015 Map (addr[7:0]): 0x00 ID RO = DEV_ID; 0x01 VER RO = 8'h01; 0x02 SCRATCH RW; 0x03 CTRL; 0x04-0x07 TMR bytes 0..3 RO; all others read 8'h00, writes dropped.
REQ-016 CTRL: bit0 tmr_en RW; bit1 tmr_clr write-1 self-clearing, reads 0; bits7:2 read 0.
REQ-017 Read latency: fx_q SHALL update on the cycle after fx_rd and hold until the next fx_rd.
REQ-018 Counter: when tmr_en=1 and pluse_us=1, tmr_val SHALL increment by 1, wrapping 32'hFFFFFFFF -> 0; with tmr_en=0 it holds.
REQ-019 tmr_clr: a write with bit1=1 SHALL zero tmr_val on the next edge; clear takes priority over a simultaneous increment.
REQ-020 Snapshot: a read of 0x04 SHALL return byte0 of the live tmr_val and, on the same edge, latch the full 32-bit value into a shadow register.
REQ-021 Reads of 0x05-0x07 SHALL return bytes 1-3 of the shadow, not the live counter.
REQ-022 Simultaneous fx_wr and fx_rd SHALL both be serviced; a read of a register written in the same cycle returns the pre-write value.
REQ-023 Writes to RO registers SHALL have no effect.

Reset
REQ-024 On rst_n low: fx_q=0, SCRATCH=0, tmr_en=0, tmr_val=0, shadow=0, immediately and independent of clk_sys.
REQ-025 Reset asserted mid-count or mid-read SHALL discard all state; the first access after release behaves as from power-up.

Structure
REQ-026 Register offsets, VER value and CTRL bit positions SHALL live in the shared fx package.
REQ-027 The counter, with its clear/enable logic and snapshot shadow, SHALL be one sub-module, us_timer; decode and read mux stay in fx_reg_bank.

Verification
REQ-028 After reset, read 0x0000 -> fx_q=8'hA5 one cycle after fx_rd; read 0x0001 -> 8'h01; read 0x0003 -> 8'h00.
REQ-029 Write 0x0002=8'h3C, then read 0x0002 -> 8'h3C; write 0x0102=8'hFF, then read 0x0002 -> still 8'h3C; read 0x0102 -> 8'h00.
REQ-030 Write CTRL=8'h01, apply 1000 pluse_us strobes, read 0x04..0x07 -> 8'hE8,8'h03,8'h00,8'h00; read CTRL -> 8'h01.
REQ-031 Preload counter to 32'hFFFFFFFE via a force, enable, apply 2 strobes -> tmr_val=0; read 0x04, then apply 5 strobes, then read 0x05 -> shadow byte1=8'h00 while live is 5.
REQ-032 Write CTRL=8'h03 in the same cycle as a pluse_us strobe -> tmr_val=0 next edge, tmr_en=1; CTRL readback=8'h01.
REQ-033 Assert rst_n mid-count with tmr_val=1234 -> all outputs 0 asynchronously; after release, read 0x0002 -> 8'h00.
